imm_ext_ctrl: RTL

IMM_EXT_CTRL -- requirements
Module: imm_ext_ctrl

---
 rtl/imm_ext_ctrl_pkg.sv | 52 +++++
 rtl/imm_ext_ctrl_sign_ext.sv | 33 +++
 rtl/imm_ext_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/imm_ext_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_ctrl_pkg
//   Shared definitions for the immediate-extension controller:
//     - ext_mode_e  : extension modes (sign / zero / upper-half)
//     - state_e     : output-buffer FSM encoding (EMPTY / ONE / FULL)
//     - OP_*        : opcode constants (instr[31:26])
//     - ext_mode_of : opcode -> extension mode decode
//     - opcode_listed : 1 for opcodes the decoder knows about
// -----------------------------------------------------------------------------
package imm_ext_ctrl_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_UPPER = 2'b10
    } ext_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_MEM_LO = 6'h20;  // first load/store opcode
    localparam logic [5:0] OP_MEM_HI = 6'h2B;  // last load/store opcode

    // Unlisted opcodes fall through to sign extension.
    function automatic ext_mode_e ext_mode_of(input logic [5:0] op);
        if (op >= OP_ANDI && op <= OP_XORI)
            return EXT_ZERO;
        if (op == OP_LUI)
            return EXT_UPPER;
        return EXT_SIGN;
    endfunction

    function automatic logic opcode_listed(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) ||
               (op >= OP_ADDI && op <= OP_LUI) ||
               (op >= OP_MEM_LO && op <= OP_MEM_HI);
    endfunction

endpackage

// File: rtl/imm_ext_ctrl_sign_ext.sv
// -----------------------------------------------------------------------------
// imm_ext_ctrl_sign_ext
//   Combinational immediate extender.
//   Ports:
//     i_signal         [i_NBITS-1:0]  raw immediate field
//     i_extension_mode [1:0]          EXT_SIGN / EXT_ZERO / EXT_UPPER
//     o_ext_signal     [NBITS-1:0]    extended immediate
//   Mode 2'b11 is unused and behaves as sign extension.
// -----------------------------------------------------------------------------
module imm_ext_ctrl_sign_ext
    import imm_ext_ctrl_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int i_NBITS = 16
) (
    input  logic [i_NBITS-1:0] i_signal,
    input  logic [1:0]         i_extension_mode,
    output logic [NBITS-1:0]   o_ext_signal
);

    logic [NBITS-1:0] zext;

    always_comb begin
        zext         = {{(NBITS-i_NBITS){1'b0}}, i_signal};
        o_ext_signal = {{(NBITS-i_NBITS){i_signal[i_NBITS-1]}}, i_signal};
        case (i_extension_mode)
            EXT_ZERO:  o_ext_signal = zext;
            EXT_UPPER: o_ext_signal = zext << i_NBITS;
            default:   ;
        endcase
    end

endmodule

// File: rtl/imm_ext_ctrl.sv
// -----------------------------------------------------------------------------
// imm_ext_ctrl
//   Decodes the opcode of an incoming instruction, extends its immediate and
//   queues the result in a 2-entry FIFO with valid/ready handshakes on both
//   sides. Latency is one cycle when the buffer is empty.
//   Ports:
//     i_clk, i_reset_n       clock, asynchronous active-low reset
//     i_instr, i_valid       instruction from IF/ID and its valid
//     o_ready                registered ready (low in FULL and in reset)
//     i_flush                drop all buffered entries at the next edge
//     o_valid, i_ready       output handshake towards ID/EX
//     o_ext_imm              extended immediate of the head entry
//     o_ext_mode             extension mode of the head entry
//     o_opcode               instr[31:26] of the head entry
//     o_illegal              head opcode is unlisted (only with
//                            IMM_EXT_CTRL_ILLEGAL_EN defined)
//   Data outputs read as zero while o_valid is low.
// -----------------------------------------------------------------------------
module imm_ext_ctrl
    import imm_ext_ctrl_pkg::*;
#(
    parameter int NBITS   = 32,
    parameter int i_NBITS = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [NBITS-1:0] i_instr,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [NBITS-1:0] o_ext_imm,
    output logic [1:0]       o_ext_mode,
    output logic [5:0]       o_opcode
`ifdef IMM_EXT_CTRL_ILLEGAL_EN
   ,output logic             o_illegal
`endif
);

    state_e           state_q, state_d;
    logic             ready_q;
    logic             accept, xfer;
    logic             wr0, wr1, shift;

    logic [5:0]       op_new;
    ext_mode_e        mode_new;
    logic [NBITS-1:0] imm_new;
    logic             instr_unused;

    // Slot 0 is always the head entry.
    logic [NBITS-1:0] imm_q  [2];
    logic [1:0]       mode_q [2];
    logic [5:0]       op_q   [2];

    assign op_new       = i_instr[31:26];
    assign mode_new     = ext_mode_of(op_new);
    assign instr_unused = ^i_instr[25:i_NBITS];

    imm_ext_ctrl_sign_ext #(
        .NBITS   (NBITS),
        .i_NBITS (i_NBITS)
    ) u_sign_ext (
        .i_signal         (i_instr[i_NBITS-1:0]),
        .i_extension_mode (mode_new),
        .o_ext_signal     (imm_new)
    );

    assign o_ready = ready_q;
    assign o_valid = (state_q != ST_EMPTY);
    assign accept  = i_valid & ready_q;
    assign xfer    = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        wr0     = 1'b0;
        wr1     = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    wr0     = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    wr0 = 1'b1;
                end else if (accept) begin
                    state_d = ST_FULL;
                    wr1     = 1'b1;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    state_d = ST_ONE;
                    shift   = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (i_flush) begin
            state_d = ST_EMPTY;
            wr0     = 1'b0;
            wr1     = 1'b0;
            shift   = 1'b0;
        end
    end

    // ready is derived from the next state so it stays registered and has
    // no combinational path from i_ready.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                imm_q[i]  <= '0;
                mode_q[i] <= '0;
                op_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            if (i_flush) begin
                for (int unsigned i = 0; i < 2; i++) begin
                    imm_q[i]  <= '0;
                    mode_q[i] <= '0;
                    op_q[i]   <= '0;
                end
            end else begin
                if (shift) begin
                    imm_q[0]  <= imm_q[1];
                    mode_q[0] <= mode_q[1];
                    op_q[0]   <= op_q[1];
                end
                if (wr0) begin
                    imm_q[0]  <= imm_new;
                    mode_q[0] <= mode_new;
                    op_q[0]   <= op_new;
                end
                if (wr1) begin
                    imm_q[1]  <= imm_new;
                    mode_q[1] <= mode_new;
                    op_q[1]   <= op_new;
                end
            end
        end
    end

    assign o_ext_imm  = o_valid ? imm_q[0]  : '0;
    assign o_ext_mode = o_valid ? mode_q[0] : '0;
    assign o_opcode   = o_valid ? op_q[0]   : '0;

`ifdef IMM_EXT_CTRL_ILLEGAL_EN
    logic ill_q [2];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ill_q[0] <= 1'b0;
            ill_q[1] <= 1'b0;
        end else if (i_flush) begin
            ill_q[0] <= 1'b0;
            ill_q[1] <= 1'b0;
        end else begin
            if (shift) ill_q[0] <= ill_q[1];
            if (wr0)   ill_q[0] <= ~opcode_listed(op_new);
            if (wr1)   ill_q[1] <= ~opcode_listed(op_new);
        end
    end

    assign o_illegal = o_valid & ill_q[0];
`endif

endmodule
